// File: rtl/vram_arbiter.sv
// Video RAM slot arbiter: fixed priority video fetch > buffered CPU writes > DMA.
// One RAM slot per clk_sys cycle; read data returns two edges after its grant.
module vram_arbiter #(
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned AW          = 15
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_valid,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          wfifo_full,
  output logic [7:0]    wr_ovf_cnt,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          dma_ack,
  output logic [7:0]    dma_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);
  localparam int unsigned PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam logic [PW:0] FullCount = (PW+1)'(WFIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StAck, StRd1, StRd2} dma_state_e;
  dma_state_e dma_state_q, dma_state_d;

  logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [7:0]    fifo_data_q [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    ovf_q, ovf_d;

  logic          fifo_empty, grant_fifo, grant_dma, push, drop;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          rd_vid, rd_dma;
  logic          tag1_vid_q, tag1_dma_q, tag2_vid_q, tag2_dma_q;
  logic [7:0]    vid_dout_q, dma_dout_q;
  logic          vid_valid_q, dma_ack_q;

  assign wfifo_full = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);

  // An empty FIFO cannot pop, so a push into an empty FIFO is simply stored.
  assign grant_fifo = !vid_req && !fifo_empty;
  assign grant_dma  = !vid_req && fifo_empty && (dma_state_q == StWait) && dma_req;
  assign push       = cpu_wr && (!wfifo_full || grant_fifo);
  assign drop       = cpu_wr && wfifo_full && !grant_fifo;

  always_comb begin
    count_d = count_q;
    if (push && !grant_fifo) begin
      count_d = count_q + (PW+1)'(1);
    end else if (grant_fifo && !push) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    rd_vid     = 1'b0;
    rd_dma     = 1'b0;
    if (vid_req) begin
      ram_addr_d = vid_addr;
      rd_vid     = 1'b1;
    end else if (grant_fifo) begin
      ram_addr_d = fifo_addr_q[rd_ptr_q];
      ram_din_d  = fifo_data_q[rd_ptr_q];
      ram_we_d   = 1'b1;
    end else if (grant_dma) begin
      ram_addr_d = dma_addr;
      ram_din_d  = dma_din;
      ram_we_d   = dma_we;
      rd_dma     = !dma_we;
    end
  end

  always_comb begin
    dma_state_d = dma_state_q;
    unique case (dma_state_q)
      StIdle: if (dma_req) dma_state_d = StWait;
      StWait: begin
        if (!dma_req) begin
          dma_state_d = StIdle;
        end else if (grant_dma) begin
          dma_state_d = dma_we ? StAck : StRd1;
        end
      end
      StAck:   dma_state_d = StIdle;
      StRd1:   dma_state_d = StRd2;
      StRd2:   dma_state_d = StIdle;
      default: dma_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      dma_state_q <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      tag1_vid_q  <= 1'b0;
      tag1_dma_q  <= 1'b0;
      tag2_vid_q  <= 1'b0;
      tag2_dma_q  <= 1'b0;
      vid_dout_q  <= '0;
      vid_valid_q <= 1'b0;
      dma_dout_q  <= '0;
      dma_ack_q   <= 1'b0;
    end else begin
      dma_state_q <= dma_state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (grant_fifo) rd_ptr_q <= rd_ptr_q + PW'(1);
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      // RAM registers its output one edge after the address; capture on the next.
      tag1_vid_q  <= rd_vid;
      tag1_dma_q  <= rd_dma;
      tag2_vid_q  <= tag1_vid_q;
      tag2_dma_q  <= tag1_dma_q;
      vid_valid_q <= tag2_vid_q;
      if (tag2_vid_q) vid_dout_q <= ram_dout;
      dma_ack_q   <= (dma_state_q == StAck) || tag2_dma_q;
      if (tag2_dma_q) dma_dout_q <= ram_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_din;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign vid_dout   = vid_dout_q;
  assign vid_valid  = vid_valid_q;
  assign dma_dout   = dma_dout_q;
  assign dma_ack    = dma_ack_q;
  assign wr_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table plus directed multi-cycle sequences.
module tb_vram_arbiter;
  localparam int AW    = 15;
  localparam int DEPTH = 4;
  localparam int OP_VID  = 0;
  localparam int OP_DMAR = 1;
  localparam int OP_DMAW = 2;
  localparam int OP_CPUW = 3;

  logic          clk_sys = 1'b0;
  logic          nRESET  = 1'b1;
  logic          vid_req, cpu_wr, dma_req, dma_we;
  logic [AW-1:0] vid_addr, cpu_addr, dma_addr, ram_addr;
  logic [7:0]    cpu_din, dma_din, vid_dout, dma_dout, ram_din, ram_dout, wr_ovf_cnt;
  logic          vid_valid, wfifo_full, dma_ack, ram_we;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter #(.WFIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .wfifo_full(wfifo_full), .wr_ovf_cnt(wr_ovf_cnt),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_dout(dma_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM model with a write log for ordering checks.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;
  int            cyc = 0;
  int            log_addr[$];
  int            log_data[$];
  int            log_cyc[$];

  always @(posedge clk_sys) begin
    cyc      <= cyc + 1;
    ram_dout <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      log_addr.push_back(int'(ram_addr));
      log_data.push_back(int'(ram_din));
      log_cyc.push_back(cyc);
    end
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  typedef struct {
    int op;
    int addr;
    int din;
    int exp_data;
    int exp_lat;
  } vec_t;

  vec_t vecs[9];
  int   b2b_addr[4];
  int   b2b_exp[4];
  int   checks = 0;
  int   errors = 0;
  int   n, cnt, base;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input int a, input int d);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = 8'(d);
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " vid_dout"}, vid_dout, 0);
    chk({tag, " vid_valid"}, vid_valid, 0);
    chk({tag, " dma_ack"}, dma_ack, 0);
    chk({tag, " dma_dout"}, dma_dout, 0);
    chk({tag, " ram_addr"}, ram_addr, 0);
    chk({tag, " ram_din"}, ram_din, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " wr_ovf_cnt"}, wr_ovf_cnt, 0);
    chk({tag, " wfifo_full"}, wfifo_full, 0);
  endtask

  task automatic check_log(input int b, input int a0, input int d0, input int num,
                           input string tag);
    chk({tag, " write count"}, log_addr.size() - b, num);
    for (int i = 0; i < num && (b + i) < log_addr.size(); i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), log_addr[b+i], a0 + i);
      chk($sformatf("%s wr%0d data", tag, i), log_data[b+i], d0 + i);
      if (i > 0) chk($sformatf("%s wr%0d spacing", tag, i), log_cyc[b+i] - log_cyc[b+i-1], 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  lat;
    int  b;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    b    = log_addr.size();
    case (v.op)
      OP_VID: begin
        vid_req  = 1'b1;
        vid_addr = AW'(v.addr);
      end
      OP_DMAR, OP_DMAW: begin
        dma_req  = 1'b1;
        dma_we   = (v.op == OP_DMAW);
        dma_addr = AW'(v.addr);
        dma_din  = 8'(v.din);
      end
      default: begin
        cpu_wr   = 1'b1;
        cpu_addr = AW'(v.addr);
        cpu_din  = 8'(v.din);
      end
    endcase
    while (!seen && lat < 10) begin
      tick();
      lat++;
      vid_req = 1'b0;
      cpu_wr  = 1'b0;
      case (v.op)
        OP_VID:  seen = vid_valid;
        OP_CPUW: seen = (log_addr.size() > b);
        default: seen = dma_ack;
      endcase
    end
    dma_req = 1'b0;
    chk($sformatf("vec%0d latency", idx), lat, v.exp_lat);
    if (v.op == OP_VID) chk($sformatf("vec%0d vid_dout", idx), vid_dout, v.exp_data);
    if (v.op == OP_DMAR) chk($sformatf("vec%0d dma_dout", idx), dma_dout, v.exp_data);
    if (v.op == OP_CPUW && log_addr.size() > b) begin
      chk($sformatf("vec%0d ram addr", idx), log_addr[b], v.addr);
      chk($sformatf("vec%0d ram data", idx), log_data[b], v.din);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vid_req = 0; vid_addr = '0; cpu_wr = 0; cpu_addr = '0; cpu_din = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    vecs[0] = '{OP_VID,  'h0000, 0,     'h01, 3};
    vecs[1] = '{OP_VID,  'h7FFF, 0,     'hFE, 3};
    vecs[2] = '{OP_DMAW, 'h1234, 'hC3,  0,    3};
    vecs[3] = '{OP_DMAR, 'h1234, 0,     'hC3, 4};
    vecs[4] = '{OP_CPUW, 'h2000, 'h9D,  0,    3};
    vecs[5] = '{OP_VID,  'h2000, 0,     'h9D, 3};
    vecs[6] = '{OP_DMAR, 'h7FFF, 0,     'hFE, 4};
    vecs[7] = '{OP_DMAW, 'h0000, 'h3C,  0,    3};
    vecs[8] = '{OP_VID,  'h0000, 0,     'h3C, 3};
    b2b_addr = '{'h0000, 'h7FFF, 'h1800, 'h2000};
    b2b_exp  = '{'h3C, 'hFE, 'h5A, 'h9D};

    #2 nRESET = 1'b0;
    preload('h0000, 'h01);
    preload('h7FFF, 'hFE);
    preload('h1800, 'h5A);
    preload('h0100, 'h11);
    check_reset("init");
    nRESET = 1'b1;
    tick();

    // Video latency: grant at edge 0, data strobe after edge 2.
    vid_req = 1; vid_addr = AW'('h1800);
    tick();
    vid_req = 0;
    chk("vid ram_addr e0", ram_addr, 'h1800);
    chk("vid ram_we e0", ram_we, 0);
    chk("vid valid e0", vid_valid, 0);
    tick();
    chk("vid valid e1", vid_valid, 0);
    tick();
    chk("vid valid e2", vid_valid, 1);
    chk("vid dout e2", vid_dout, 'h5A);
    tick();
    chk("vid valid e3", vid_valid, 0);

    // Reset mid-read with a buffered CPU write pending.
    vid_req = 1; cpu_wr = 1; cpu_addr = AW'('h0777); cpu_din = 8'h77;
    tick();
    cpu_wr = 0;
    tick();
    vid_req = 0; nRESET = 0;
    #1;
    check_reset("midrst");
    tick();
    tick();
    chk("midrst valid held low", vid_valid, 0);
    nRESET = 1;
    base = log_addr.size();
    cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(vid_valid);
    end
    chk("midrst no vid_valid", cnt, 0);
    chk("midrst fifo empty", log_addr.size() - base, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back video fetches: one strobe per cycle.
    for (int i = 0; i < 6; i++) begin
      vid_req = (i < 4);
      if (i < 4) vid_addr = AW'(b2b_addr[i]);
      tick();
      if (i >= 2) begin
        chk($sformatf("b2b%0d valid", i - 2), vid_valid, 1);
        chk($sformatf("b2b%0d dout", i - 2), vid_dout, b2b_exp[i-2]);
      end
    end
    tick();
    chk("b2b valid end", vid_valid, 0);

    // FIFO overflow while video holds every slot.
    vid_req = 1; vid_addr = '0;
    for (int i = 0; i < 6; i++) begin
      cpu_wr = 1; cpu_addr = AW'('h0200 + i); cpu_din = 8'('h10 + i);
      tick();
    end
    cpu_wr = 0;
    chk("ovf full", wfifo_full, 1);
    chk("ovf count", wr_ovf_cnt, 2);
    base = log_addr.size();
    vid_req = 0;
    repeat (7) tick();
    check_log(base, 'h0200, 'h10, 4, "ovf drain");
    chk("ovf drained not full", wfifo_full, 0);

    // Write into a full FIFO on the same edge as a pop is accepted.
    vid_req = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1; cpu_addr = AW'('h0300 + i); cpu_din = 8'('h20 + i);
      tick();
    end
    chk("pushpop full before", wfifo_full, 1);
    base = log_addr.size();
    vid_req = 0; cpu_wr = 1; cpu_addr = AW'('h0304); cpu_din = 8'h24;
    tick();
    cpu_wr = 0;
    chk("pushpop still full", wfifo_full, 1);
    chk("pushpop ovf unchanged", wr_ovf_cnt, 2);
    repeat (7) tick();
    check_log(base, 'h0300, 'h20, 5, "pushpop");

    // DMA read waits for the earlier CPU write to drain.
    cpu_wr = 1; cpu_addr = AW'('h0100); cpu_din = 8'hAA;
    dma_req = 1; dma_we = 0; dma_addr = AW'('h0100);
    tick();
    cpu_wr = 0;
    chk("ord e0 ram_we", ram_we, 0);
    tick();
    chk("ord pop ram_we", ram_we, 1);
    chk("ord pop ram_addr", ram_addr, 'h0100);
    chk("ord pop ram_din", ram_din, 'hAA);
    tick();
    chk("ord dma grant ram_we", ram_we, 0);
    chk("ord dma grant ram_addr", ram_addr, 'h0100);
    n = 0;
    while (!dma_ack && n < 6) begin
      tick();
      n++;
    end
    dma_req = 0;
    chk("ord ack after grant", n, 2);
    chk("ord dma_dout", dma_dout, 'hAA);
    tick();

    // Priority collision: video, then FIFO, then DMA write.
    vid_req = 1; vid_addr = AW'('h0500);
    cpu_wr = 1; cpu_addr = AW'('h0600); cpu_din = 8'h33;
    dma_req = 1; dma_we = 1; dma_addr = AW'('h0400); dma_din = 8'h44;
    tick();
    cpu_wr = 0;
    tick();
    chk("prio vid ram_addr", ram_addr, 'h0500);
    chk("prio vid ram_we", ram_we, 0);
    vid_req = 0;
    tick();
    chk("prio fifo ram_we", ram_we, 1);
    chk("prio fifo ram_addr", ram_addr, 'h0600);
    chk("prio fifo ram_din", ram_din, 'h33);
    chk("prio fifo no ack", dma_ack, 0);
    tick();
    chk("prio dma ram_we", ram_we, 1);
    chk("prio dma ram_addr", ram_addr, 'h0400);
    chk("prio dma ram_din", ram_din, 'h44);
    chk("prio dma no ack yet", dma_ack, 0);
    tick();
    chk("prio dma ack", dma_ack, 1);
    chk("prio ram_we idle", ram_we, 0);
    dma_req = 0;
    tick();
    chk("prio ack strobe", dma_ack, 0);
    chk("prio mem written", mem['h0400], 'h44);

    // DMA abort while video owns the slot.
    vid_req = 1; vid_addr = '0;
    base = log_addr.size();
    dma_req = 1; dma_we = 1; dma_addr = AW'('h0450); dma_din = 8'h55;
    tick();
    dma_req = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) vid_req = 0;
      tick();
      cnt += int'(dma_ack);
    end
    chk("abort no ack", cnt, 0);
    chk("abort no write", log_addr.size() - base, 0);
    dma_req = 1;
    n = 0;
    while (!dma_ack && n < 8) begin
      tick();
      n++;
    end
    dma_req = 0;
    chk("abort restart latency", n, 3);
    tick();

    // Drop counter saturates at 255.
    vid_req = 1;
    for (int i = 0; i < 260; i++) begin
      cpu_wr = 1; cpu_addr = AW'(i); cpu_din = 8'(i);
      tick();
    end
    cpu_wr = 0;
    chk("ovf saturate", wr_ovf_cnt, 255);
    vid_req = 0;
    repeat (6) tick();
    chk("sat drained", wfifo_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 32 KB video RAM (screen pages 5/7, 15-bit address) between three requesters: ULA video fetch, CPU shadow writes and a DMA/snapshot port.
- Each clk_sys cycle is one RAM slot.
- Fixed priority: video fetch first, then the buffered CPU write FIFO, then DMA.
- Sits between the ULA and the video BRAM; the ULA's fetch address and data connect to the vid_* port.

Parameters:
WFIFO_DEPTH, 4, CPU write FIFO entries (power of two, 2..16)
AW, 15, RAM address width

Ports:
clk_sys  in  1  master clock
nRESET  in  1  asynchronous active-low reset
vid_req  in  1  video fetch request, sampled every clk_sys edge
vid_addr  in  AW  video fetch address
vid_dout  out  8  fetched byte
vid_valid  out  1  one-cycle strobe, vid_dout valid
cpu_wr  in  1  one-cycle CPU write pulse into VRAM
cpu_addr  in  AW  CPU write address
cpu_din  in  8  CPU write data
wfifo_full  out  1  FIFO holds WFIFO_DEPTH entries
wr_ovf_cnt  out  8  saturating count of dropped CPU writes
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  DMA write(1)/read(0), stable while dma_req
dma_addr  in  AW  DMA address
dma_din  in  8  DMA write data
dma_ack  out  1  one-cycle completion strobe
dma_dout  out  8  DMA read data, valid with dma_ack
ram_addr  out  AW  registered RAM address
ram_din  out  8  registered RAM write data
ram_we  out  1  registered RAM write enable
ram_dout  in  8  RAM read data, one-edge synchronous read latency

Behaviour:
- Reset (nRESET low, asynchronous): FIFO emptied; DMA FSM to IDLE; in-flight read tags cleared. All outputs 0: vid_dout, vid_valid, dma_ack, dma_dout, ram_addr, ram_din, ram_we, wr_ovf_cnt. wfifo_full is 0.
- Grant per edge k, evaluated in priority order:
  1. vid_req=1: ram_addr<=vid_addr, ram_we<=0.
  2. Else FIFO non-empty: pop the head; ram_addr/ram_din<=entry, ram_we<=1.
  3. Else DMA FSM in WAIT: ram_addr<=dma_addr, ram_we<=dma_we, ram_din<=dma_din.
  4. Else ram_we<=0. ram_addr and ram_din hold their values.
- Read pipeline: a 2-stage tag {vid, dma} tracks reads granted at edge k. RAM output is registered at edge k+1. Data is captured at edge k+2 into vid_dout with vid_valid=1, or into dma_dout with dma_ack=1, for one cycle. Back-to-back vid_req every cycle gives one vid_valid per cycle.
- CPU FIFO: cpu_wr is accepted if not full, or if full and a pop occurs on the same edge; count is then unchanged. A write to a full FIFO with no pop is dropped and wr_ovf_cnt increments, saturating at 255. Simultaneous push and pop on an empty FIFO: the push is stored and the pop does not occur.
- Ordering: entries drain in FIFO order. No DMA grant (read or write) while the FIFO is non-empty. DMA therefore always sees all earlier CPU writes. Video reads are not ordered against pending FIFO writes; stale data is allowed.
- DMA FSM:
  - IDLE: dma_req=1 goes to WAIT.
  - WAIT: on grant, a write goes to ACK and a read goes to RD1. If dma_req drops before grant, return to IDLE with no RAM access.
  - ACK: dma_ack=1 for one cycle; go to IDLE.
  - RD1: go to RD2.
  - RD2: capture ram_dout; dma_ack=1; go to IDLE.
  - Write ack: 1 edge after grant. Read ack: 2 edges after grant.
  - dma_req still high in IDLE after an ack starts a new transaction; minimum spacing is 1 idle cycle.
- Starvation: video has absolute priority, and the FIFO blocks DMA. The ULA duty cycle bounds video slots; no further guard.
- wfifo_full is combinational from the count.

Test Plan:
- Reset mid-read: vid_req at edge 0, nRESET low before edge 2 -> no vid_valid; all outputs 0; FIFO empty.
- Video latency: vid_req=1 with addr 0x1800 (RAM[0x1800]=0x5A) sampled at edge 0 -> ram_addr=0x1800 after edge 0; vid_valid=1 and vid_dout=0x5A after edge 2.
- FIFO overflow: 6 cpu_wr pulses with vid_req held high -> first 4 stored, wfifo_full=1, wr_ovf_cnt=2. Release vid_req -> 4 writes appear on ram_we in order on consecutive edges.
- DMA ordering: cpu_wr(0x0100,0xAA) then immediately DMA read 0x0100 -> dma_ack returns 0xAA; DMA grant follows the FIFO pop.
- Priority collision: vid_req, FIFO entry and DMA write all pending -> slot order is video, FIFO, DMA. DMA write ack comes 1 edge after its grant.
- DMA abort: dma_req pulses 1 cycle while vid_req is held -> FSM returns to IDLE, no ram_we, no dma_ack.
